sprite_pixel_fetch: RTL and testbench
=====================================

Name: sprite_pixel_fetch

Overview:
- Upstream neighbour of the 12-bit-to-24-bit palette stage.
- Takes the VGA scan position (DrawX/DrawY) and produces a 12-bit colour code (RGB_12) plus an aligned DrawX_out for the palette.
- Hit-tests one animated sprite, reads its pixel from a synchronous sprite ROM, and applies colour-key transparency.
- Background and transparent pixels both emit 12'h000, which the palette renders as its DrawX gradient.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2).
- SPR_H, 32, sprite height in pixels.
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM.
- ANIM_DIV, 8, video frames per animation step.
- ADDR_W, 12, ROM address width (must be ≥ log2(SPR_W*SPR_H*NUM_FRAMES)).
- KEY, 12'h000, transparent colour code.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- pixel_en  in  1  one-cycle pixel strobe; the pipeline advances only when this is 1.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- blank_n  in  1  active video when 1.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- sprite_x  in  10  requested sprite left edge.
- sprite_y  in  10  requested sprite top edge.
- sprite_show  in  1  requested sprite visibility.
- rom_addr  out  ADDR_W  sprite ROM address (registered).
- rom_data  in  12  ROM output; valid 1 Clk after rom_addr changes, then held.
- RGB_12  out  12  colour code to palette.
- DrawX_out  out  10  DrawX aligned with RGB_12.
- sprite_hit  out  1  1 when RGB_12 is an opaque sprite pixel.

Behaviour:
- Reset (synchronous) clears all registers:
  - Outputs: rom_addr=0, RGB_12=12'h000, DrawX_out=0, sprite_hit=0.
  - Internal: shadow x/y=0, shadow show=0, frame counter=0, anim_idx=0, pipeline valid/hit flags=0.
- Reset takes priority over frame_start and pixel_en in the same cycle.
- Reset mid-frame: the sprite stays invisible until the first frame_start after Reset deasserts.
- Shadow latch:
  - On frame_start, sprite_x/y/show are copied into shadow registers.
  - Stage 0 always uses the shadow values, never the raw inputs, so a sprite never tears mid-frame.
  - If pixel_en and frame_start coincide, stage 0 uses the pre-update shadow values.
- Animation:
  - frame_cnt (width ⌈log2 ANIM_DIV⌉) increments on each frame_start.
  - When frame_cnt == ANIM_DIV-1 it wraps to 0 and anim_idx increments modulo NUM_FRAMES (3 -> 0).
  - anim_idx changes only on frame_start.
- Stage 0 (on pixel_en):
  - Compare in 11-bit arithmetic so sx+SPR_W cannot overflow: hit0 = show & blank_n & (DrawX ≥ sx) & (DrawX < sx+SPR_W) & (DrawY ≥ sy) & (DrawY < sy+SPR_H).
  - Off-screen edges clip naturally; no wrap-around to column 0.
  - If hit0: rom_addr <= anim_idx*SPR_W*SPR_H + (DrawY-sy)*SPR_W + (DrawX-sx), truncated to ADDR_W.
  - If not hit0: rom_addr holds its previous value.
  - Register hit0, blank_n and DrawX into stage-0 registers.
- Stage 1 (on the next pixel_en): samples rom_data, which is guaranteed settled since pixel_en spacing is ≥2 Clk.
  - opaque = hit0_d & (rom_data != KEY).
  - RGB_12 <= opaque ? rom_data : 12'h000.
  - sprite_hit <= opaque.
  - DrawX_out <= DrawX_d.
  - If blank_n_d == 0: RGB_12 <= 12'h000 and sprite_hit <= 0.
- Latency: exactly 2 pixel_en strobes from a DrawX/DrawY sample to the matching RGB_12/DrawX_out. Outputs change only in cycles where pixel_en is 1.
- pixel_en low: every register holds.

Test Plan:
1. Reset mid-frame with sprite_show=1 and DrawX=DrawY=100 inside the sprite -> RGB_12=12'h000 and sprite_hit=0 every pixel until the next frame_start; after it, a pixel at sprite origin (100,100) yields ROM[0].
2. Shadow at (100,50), ROM[33]=12'hb40, scan (101,51) -> rom_addr=33 after the first strobe; after the second strobe RGB_12=12'hb40, DrawX_out=101, sprite_hit=1.
3. Colour key: ROM[0]=12'h000 at (100,50) -> RGB_12=12'h000, sprite_hit=0. Boundaries (sprite at 100,50):
   - DrawX=99 and DrawX=132 -> no hit, rom_addr unchanged.
   - DrawX=131, DrawY=81 -> rom_addr=1023.
4. Clipping: sprite_x=620 -> pixels at DrawX 620..639 hit; no hit at DrawX 0..11 on the same row.
5. Animation: 8 frame_start pulses -> anim_idx=1, and a pixel at origin reads rom_addr=1024. After 32 pulses anim_idx wraps to 0. frame_start coinciding with a hitting pixel_en -> stage 0 uses the old position.
6. Blanking: blank_n=0 over a sprite pixel -> RGB_12=12'h000, sprite_hit=0. With pixel_en low for 5 cycles, all outputs hold their previous values.

Source files
------------

// File: rtl/sprite_pixel_fetch.sv
// rtl/sprite_pixel_fetch.sv - sprite hit-test, ROM fetch and colour-key stage ahead of the palette
module sprite_pixel_fetch #(
  parameter int          SPR_W      = 32,
  parameter int          SPR_H      = 32,
  parameter int          NUM_FRAMES = 4,
  parameter int          ANIM_DIV   = 8,
  parameter int          ADDR_W     = 12,
  parameter logic [11:0] KEY        = 12'h000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_en,
  input  logic              frame_start,
  input  logic              blank_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_show,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       RGB_12,
  output logic [9:0]        DrawX_out,
  output logic              sprite_hit
);

  localparam int FC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int AI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(ANIM_DIV - 1);
  localparam logic [AI_W-1:0] AI_LAST = AI_W'(NUM_FRAMES - 1);

  // Shadow copy of the requested sprite placement, only refreshed in vertical blank
  logic [9:0]      sx;
  logic [9:0]      sy;
  logic            show;

  // Animation pacing
  logic [FC_W-1:0] frame_cnt;
  logic [AI_W-1:0] anim_idx;

  // Stage-0 pipeline registers
  logic            hit0_d;
  logic            blank_n_d;
  logic [9:0]      drawx_d;

  // Stage-0 combinational hit test and address
  logic [10:0]     x_end;
  logic [10:0]     y_end;
  logic            hit0;
  logic [9:0]      dx;
  logic [9:0]      dy;
  logic [ADDR_W-1:0] addr_next;
  logic            opaque;

  // Hit test in 11 bits so a sprite hanging off the right/bottom edge never wraps to column/row 0
  always_comb begin
    x_end = {1'b0, sx} + 11'(SPR_W);
    y_end = {1'b0, sy} + 11'(SPR_H);
    hit0  = show & blank_n &
            ({1'b0, DrawX} >= {1'b0, sx}) & ({1'b0, DrawX} < x_end) &
            ({1'b0, DrawY} >= {1'b0, sy}) & ({1'b0, DrawY} < y_end);
    dx    = DrawX - sx;
    dy    = DrawY - sy;
    addr_next = ADDR_W'(anim_idx) * ADDR_W'(SPR_W * SPR_H)
              + ADDR_W'(dy) * ADDR_W'(SPR_W)
              + ADDR_W'(dx);
  end

  // Stage-1 colour key decision on the ROM word fetched for the previous pixel
  always_comb begin
    opaque = hit0_d & (rom_data != KEY);
  end

  // Shadow latch and animation counters advance only on frame_start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx        <= '0;
      sy        <= '0;
      show      <= 1'b0;
      frame_cnt <= '0;
      anim_idx  <= '0;
    end else if (frame_start) begin
      sx   <= sprite_x;
      sy   <= sprite_y;
      show <= sprite_show;
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        anim_idx  <= (anim_idx == AI_LAST) ? '0 : anim_idx + 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 0: issue the ROM address for a hitting pixel and carry pixel context forward
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      hit0_d    <= 1'b0;
      blank_n_d <= 1'b0;
      drawx_d   <= '0;
    end else if (pixel_en) begin
      if (hit0) begin
        rom_addr <= addr_next;
      end
      hit0_d    <= hit0;
      blank_n_d <= blank_n;
      drawx_d   <= DrawX;
    end
  end

  // Stage 1: present the keyed colour aligned with its column; blanking forces background
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RGB_12     <= 12'h000;
      sprite_hit <= 1'b0;
      DrawX_out  <= '0;
    end else if (pixel_en) begin
      DrawX_out <= drawx_d;
      if (!blank_n_d) begin
        RGB_12     <= 12'h000;
        sprite_hit <= 1'b0;
      end else begin
        RGB_12     <= opaque ? rom_data : 12'h000;
        sprite_hit <= opaque;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb/tb_sprite_pixel_fetch.sv - directed self-checking bench for sprite_pixel_fetch
module tb_sprite_pixel_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pixel_en;
  logic        frame_start;
  logic        blank_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        sprite_show;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] RGB_12;
  logic [9:0]  DrawX_out;
  logic        sprite_hit;

  logic [11:0] rom [0:4095];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        b;
    logic [11:0] addr;
    logic [11:0] rgb;
    logic        hit;
  } vec_t;

  vec_t vecs [9];

  sprite_pixel_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pixel_en    (pixel_en),
    .frame_start (frame_start),
    .blank_n     (blank_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_show (sprite_show),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .RGB_12      (RGB_12),
    .DrawX_out   (DrawX_out),
    .sprite_hit  (sprite_hit)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM model: one clock of read latency
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] x, input logic [9:0] y, input logic b, input logic fs);
    @(negedge Clk);
    DrawX = x; DrawY = y; blank_n = b; pixel_en = 1'b1; frame_start = fs;
    @(negedge Clk);
    pixel_en = 1'b0; frame_start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic flush();
    strobe(10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic fstart(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 12'(i) ^ 12'ha5a;
    rom[33] = 12'hb40;

    vecs[0] = '{x:10'd101, y:10'd51, b:1'b1, addr:12'd33,   rgb:12'hb40, hit:1'b1};
    vecs[1] = '{x:10'd100, y:10'd50, b:1'b1, addr:12'd0,    rgb:12'h000, hit:1'b0};
    vecs[2] = '{x:10'd99,  y:10'd50, b:1'b1, addr:12'd0,    rgb:12'h000, hit:1'b0};
    vecs[3] = '{x:10'd132, y:10'd50, b:1'b1, addr:12'd0,    rgb:12'h000, hit:1'b0};
    vecs[4] = '{x:10'd131, y:10'd81, b:1'b1, addr:12'd1023, rgb:12'h9a5, hit:1'b1};
    vecs[5] = '{x:10'd131, y:10'd82, b:1'b1, addr:12'd1023, rgb:12'h000, hit:1'b0};
    vecs[6] = '{x:10'd100, y:10'd49, b:1'b1, addr:12'd1023, rgb:12'h000, hit:1'b0};
    vecs[7] = '{x:10'd110, y:10'd60, b:1'b0, addr:12'd1023, rgb:12'h000, hit:1'b0};
    vecs[8] = '{x:10'd110, y:10'd60, b:1'b1, addr:12'd330,  rgb:12'hb10, hit:1'b1};

    Reset = 1'b1; pixel_en = 1'b0; frame_start = 1'b0; blank_n = 1'b0;
    DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0; sprite_show = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Reset mid-frame: sprite visible, then reset colliding with pixel_en and frame_start
    sprite_x = 10'd100; sprite_y = 10'd100; sprite_show = 1'b1;
    fstart(1);
    strobe(10'd101, 10'd101, 1'b1, 1'b0);
    flush();
    chk("pre_reset_rgb", RGB_12, 12'hb40);
    @(negedge Clk);
    Reset = 1'b1; pixel_en = 1'b1; frame_start = 1'b1; DrawX = 10'd100; DrawY = 10'd100; blank_n = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; pixel_en = 1'b0; frame_start = 1'b0;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_rgb", RGB_12, 0);
    chk("reset_drawx_out", DrawX_out, 0);
    chk("reset_hit", sprite_hit, 0);
    for (int i = 0; i < 3; i++) begin
      strobe(10'd100, 10'd100, 1'b1, 1'b0);
      chk("post_reset_rgb", RGB_12, 0);
      chk("post_reset_hit", sprite_hit, 0);
    end
    fstart(1);
    strobe(10'd100, 10'd100, 1'b1, 1'b0);
    chk("origin_addr", rom_addr, 0);
    flush();
    chk("origin_rgb", RGB_12, 12'ha5a);
    chk("origin_hit", sprite_hit, 1);
    chk("origin_dx", DrawX_out, 100);

    // Table: hit, key, boundaries and blanking with the sprite at (100,50)
    rom[0] = 12'h000;
    sprite_x = 10'd100; sprite_y = 10'd50;
    fstart(1);
    for (int i = 0; i < 9; i++) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].b, 1'b0);
      chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].addr);
      flush();
      chk($sformatf("vec%0d_rgb", i), RGB_12, vecs[i].rgb);
      chk($sformatf("vec%0d_hit", i), sprite_hit, vecs[i].hit);
      chk($sformatf("vec%0d_dx", i), DrawX_out, vecs[i].x);
    end

    // pixel_en low: outputs hold even with a hitting pixel on the inputs
    DrawX = 10'd131; DrawY = 10'd81; blank_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("hold_addr", rom_addr, 330);
      chk("hold_rgb", RGB_12, 12'hb10);
      chk("hold_hit", sprite_hit, 1);
      chk("hold_dx", DrawX_out, 110);
    end

    // Clipping at the right screen edge
    rom[0] = 12'ha5a;
    sprite_x = 10'd620;
    fstart(1);
    for (int x = 620; x < 640; x++) begin
      strobe(10'(x), 10'd50, 1'b1, 1'b0);
      chk("clip_addr", rom_addr, x - 620);
      flush();
      chk("clip_hit", sprite_hit, 1);
    end
    for (int x = 0; x < 12; x++) begin
      strobe(10'(x), 10'd50, 1'b1, 1'b0);
      flush();
      chk("clip_nowrap_hit", sprite_hit, 0);
      chk("clip_nowrap_addr", rom_addr, 19);
    end

    // Animation stepping from a known counter state
    do_reset();
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_show = 1'b1;
    fstart(7);
    strobe(10'd100, 10'd50, 1'b1, 1'b0);
    chk("anim7_addr", rom_addr, 0);
    flush();
    chk("anim7_rgb", RGB_12, 12'ha5a);
    fstart(1);
    strobe(10'd100, 10'd50, 1'b1, 1'b0);
    chk("anim8_addr", rom_addr, 1024);
    flush();
    chk("anim8_rgb", RGB_12, 12'he5a);
    fstart(8);
    strobe(10'd100, 10'd50, 1'b1, 1'b0);
    chk("anim16_addr", rom_addr, 2048);
    flush();
    chk("anim16_rgb", RGB_12, 12'h25a);
    fstart(16);
    strobe(10'd100, 10'd50, 1'b1, 1'b0);
    chk("anim32_addr", rom_addr, 0);

    // frame_start coinciding with pixel_en: stage 0 sees the old position
    sprite_x = 10'd300;
    strobe(10'd101, 10'd50, 1'b1, 1'b1);
    chk("coinc_addr", rom_addr, 1);
    flush();
    chk("coinc_rgb", RGB_12, 12'ha5b);
    chk("coinc_hit", sprite_hit, 1);
    strobe(10'd302, 10'd51, 1'b1, 1'b0);
    chk("newpos_addr", rom_addr, 34);
    flush();
    chk("newpos_rgb", RGB_12, 12'ha78);
    chk("newpos_dx", DrawX_out, 302);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
